// File: rtl/cpu_debug_pkg.sv
// Shared state type and default parameters for the CPU debug scanner.
// Optional timestamp capture is enabled with CPU_DEBUG_SCANNER_TIMESTAMP_EN.
package cpu_debug_pkg;

  typedef enum logic [1:0] {
    HOLD,
    SETTLE,
    CAPTURE,
    WAIT
  } scan_state_t;

  localparam int DEF_RST_CYCLES    = 1;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_LED_W         = 16;
  localparam int DEF_SSD_W         = 13;
  localparam int DEF_LED_SEL_W     = 2;
  localparam int DEF_SSD_SEL_W     = 4;
  localparam int DEF_TS_W          = 32;

  // Bits needed to count from 0 up to max_val inclusive, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dbg_cycle_counter.sv
// Width-parametrised up-counter with synchronous reset, synchronous clear and
// count enable; clear wins over enable.
module dbg_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_debug_scanner.sv
// Debug scan harness: resets the CPU, walks ledSel/ssdSel through every value
// and streams settled leds/ssd samples; CPU_DEBUG_SCANNER_TIMESTAMP_EN adds out_ts.
module cpu_debug_scanner
  import cpu_debug_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int LED_W         = DEF_LED_W,
  parameter int SSD_W         = DEF_SSD_W,
  parameter int LED_SEL_W     = DEF_LED_SEL_W,
  parameter int SSD_SEL_W     = DEF_SSD_SEL_W
`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
  ,
  parameter int TS_W          = DEF_TS_W
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 scan_en,
  output logic                 cpu_rst,
  output logic [LED_SEL_W-1:0] led_sel,
  output logic [SSD_SEL_W-1:0] ssd_sel,
  input  logic [LED_W-1:0]     leds,
  input  logic [SSD_W-1:0]     ssd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SSD_SEL_W-1:0] out_idx,
  output logic [LED_W-1:0]     out_leds,
  output logic [SSD_W-1:0]     out_ssd
`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]      out_ts
`endif
);

  // One counter serves both the reset hold and the settle wait.
  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

  scan_state_t          state;
  logic [SSD_SEL_W-1:0] idx;
  logic [CNT_W-1:0]     cnt;
  logic                 hold_done;
  logic                 settle_done;
  logic                 cnt_clr;
  logic                 cnt_en;

  assign hold_done   = (state == HOLD) && (cnt == HOLD_LAST);
  assign settle_done = (state == SETTLE) && scan_en && (cnt == SETTLE_LAST);
  assign cnt_clr     = restart || hold_done || settle_done;
  assign cnt_en      = (state == HOLD) || ((state == SETTLE) && scan_en);

  dbg_cycle_counter #(.W(CNT_W)) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

  assign led_sel = idx[LED_SEL_W-1:0];
  assign ssd_sel = idx;

  // A restart drops any pending sample, even one being handshaked this cycle.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state     <= HOLD;
      cpu_rst   <= 1'b1;
      idx       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_leds  <= '0;
      out_ssd   <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_done) begin
            cpu_rst <= 1'b0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          out_idx   <= idx;
          out_leds  <= leds;
          out_ssd   <= ssd;
          out_valid <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= idx + SSD_SEL_W'(1);
            state     <= SETTLE;
          end
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Cycles since the CPU last left reset.
  dbg_cycle_counter #(.W(TS_W)) u_ts_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cpu_rst),
    .en    (1'b1),
    .count (ts)
  );

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      out_ts <= '0;
    end else if (state == CAPTURE) begin
      out_ts <= ts;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_debug_scanner.sv
// Self-checking bench for cpu_debug_scanner: table vectors, hand sequences for
// back-pressure/gating/restart, and randomized samples against a latency model.
module tb_cpu_debug_scanner;

  localparam int RST_CYCLES    = 1;
  localparam int SETTLE_CYCLES = 4;
  localparam int LED_W         = 16;
  localparam int SSD_W         = 13;
  localparam int LED_SEL_W     = 2;
  localparam int SSD_SEL_W     = 4;
  localparam int NPOS          = 1 << SSD_SEL_W;
  localparam int HIST          = 80;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 restart;
  logic                 scan_en;
  logic                 cpu_rst;
  logic [LED_SEL_W-1:0] led_sel;
  logic [SSD_SEL_W-1:0] ssd_sel;
  logic [LED_W-1:0]     leds;
  logic [SSD_W-1:0]     ssd;
  logic                 out_valid;
  logic                 out_ready;
  logic [SSD_SEL_W-1:0] out_idx;
  logic [LED_W-1:0]     out_leds;
  logic [SSD_W-1:0]     out_ssd;
`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
  logic [31:0]          out_ts;
`endif

  typedef struct {
    logic [LED_W-1:0]     leds;
    logic [SSD_W-1:0]     ssd;
    int                   ready_wait;
    logic [SSD_SEL_W-1:0] exp_idx;
    logic [LED_W-1:0]     exp_leds;
    logic [SSD_W-1:0]     exp_ssd;
  } vec_t;

  vec_t             vecs[NPOS];
  int               checks = 0;
  int               failures = 0;
  int               next_idx = 0;
  logic [LED_W-1:0] led_hist[HIST];
  logic [SSD_W-1:0] ssd_hist[HIST];
  logic [LED_W-1:0] cap_leds;
  logic [SSD_W-1:0] cap_ssd;

  cpu_debug_scanner #(
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .LED_W         (LED_W),
    .SSD_W         (SSD_W),
    .LED_SEL_W     (LED_SEL_W),
    .SSD_SEL_W     (SSD_SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .scan_en   (scan_en),
    .cpu_rst   (cpu_rst),
    .led_sel   (led_sel),
    .ssd_sel   (ssd_sel),
    .leds      (leds),
    .ssd       (ssd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_leds  (out_leds),
    .out_ssd   (out_ssd)
`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
    ,
    .out_ts    (out_ts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Runs one settle/capture period. The sample must appear two cycles after
  // the (SETTLE_CYCLES+1)-th enabled cycle and hold the inputs seen one cycle
  // before it appears.
  task automatic runSample(input logic [31:0] en_pat, input bit rand_data, output int lat);
    int p;
    int ones;
    int k;
    logic [SSD_SEL_W-1:0] ei;
    ei   = SSD_SEL_W'(next_idx);
    p    = -1;
    ones = 0;
    for (int j = 0; j < HIST; j++) begin
      if (p < 0 && (j >= 32 || en_pat[5'(j)])) begin
        ones++;
        if (ones == SETTLE_CYCLES + 1) p = j;
      end
    end
    lat = -1;
    k   = 0;
    while (k < HIST - 1 && lat < 0) begin
      if (out_valid === 1'b1) begin
        lat = k;
      end else begin
        checkOutput("sel_stable", {ssd_sel, led_sel}, {ei, ei[LED_SEL_W-1:0]});
        scan_en = (k >= 32) ? 1'b1 : en_pat[5'(k)];
        if (rand_data) begin
          leds = LED_W'($urandom);
          ssd  = SSD_W'($urandom);
        end
        led_hist[k] = leds;
        ssd_hist[k] = ssd;
        step();
        k++;
      end
    end
    scan_en  = 1'b1;
    cap_leds = led_hist[p + 1];
    cap_ssd  = ssd_hist[p + 1];
    checkOutput("latency", lat, p + 2);
    if (lat >= 0) begin
      checkOutput("out_idx", out_idx, ei);
      checkOutput("out_leds", out_leds, cap_leds);
      checkOutput("out_ssd", out_ssd, cap_ssd);
      checkOutput("sel_at_valid", {ssd_sel, led_sel}, {ei, ei[LED_SEL_W-1:0]});
    end
  endtask

  task automatic holdCheck(input int cycles, input logic [LED_W-1:0] el, input logic [SSD_W-1:0] es);
    logic [SSD_SEL_W-1:0] ei;
    ei = SSD_SEL_W'(next_idx);
    for (int c = 0; c < cycles; c++) begin
      leds = LED_W'($urandom);
      ssd  = SSD_W'($urandom);
      step();
      checkOutput("hold", {out_valid, out_idx, out_leds, out_ssd, ssd_sel}, {1'b1, ei, el, es, ei});
    end
  endtask

  task automatic handshake();
    logic [SSD_SEL_W-1:0] ei;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    next_idx  = (next_idx + 1) % NPOS;
    ei        = SSD_SEL_W'(next_idx);
    checkOutput("hs_valid_low", out_valid, 1'b0);
    checkOutput("hs_sel", {ssd_sel, led_sel}, {ei, ei[LED_SEL_W-1:0]});
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    leds = v.leds;
    ssd  = v.ssd;
    runSample(32'hFFFF_FFFF, 1'b0, lat);
    checkOutput("tbl_idx", out_idx, v.exp_idx);
    checkOutput("tbl_leds", out_leds, v.exp_leds);
    checkOutput("tbl_ssd", out_ssd, v.exp_ssd);
    checkOutput("tbl_led_sel", led_sel, v.exp_idx[LED_SEL_W-1:0]);
    holdCheck(v.ready_wait, v.exp_leds, v.exp_ssd);
    handshake();
  endtask

  initial begin
    int n;
    int lat;

    for (int i = 0; i < NPOS; i++) begin
      vecs[i].leds       = LED_W'(32'h1111 * i) ^ 16'hA5A5;
      vecs[i].ssd        = SSD_W'(32'h0AB * i + 7);
      vecs[i].ready_wait = i % 4;
      vecs[i].exp_idx    = SSD_SEL_W'((i + 1) % NPOS);
      vecs[i].exp_leds   = vecs[i].leds;
      vecs[i].exp_ssd    = vecs[i].ssd;
    end

    rst       = 1'b1;
    restart   = 1'b0;
    scan_en   = 1'b1;
    out_ready = 1'b0;
    leds      = 16'hA5A5;
    ssd       = 13'h1234;
    step();
    checkOutput("rst_cpu_rst", cpu_rst, 1'b1);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_sel", {ssd_sel, led_sel}, '0);
    checkOutput("rst_out", {out_idx, out_leds, out_ssd}, '0);
    rst = 1'b0;

    n = 0;
    while (cpu_rst === 1'b1 && n < 20) begin
      n++;
      step();
    end
    checkOutput("cpu_rst_cycles", n, RST_CYCLES);

    runSample(32'hFFFF_FFFF, 1'b0, lat);
    checkOutput("first_latency", lat, 6);
    checkOutput("first_idx", out_idx, 4'd0);
    checkOutput("first_leds", out_leds, 16'hA5A5);
    checkOutput("first_ssd", out_ssd, 13'h1234);
`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
    checkOutput("first_ts", out_ts, 32'd5);
`endif

    holdCheck(10, 16'hA5A5, 13'h1234);
    handshake();

    for (int i = 0; i < NPOS; i++) applyStimulus(vecs[i]);

    runSample(32'hFFFF_FFE3, 1'b0, lat);
    checkOutput("gated_latency", lat, SETTLE_CYCLES + 2 + 3);
    handshake();

    for (int r = 0; r < 20; r++) begin
      runSample($urandom | $urandom, 1'b1, lat);
      holdCheck(int'($urandom_range(0, 3)), cap_leds, cap_ssd);
      handshake();
    end

    while (next_idx != 5) begin
      runSample($urandom | $urandom, 1'b1, lat);
      handshake();
    end
    runSample($urandom | $urandom, 1'b1, lat);
    out_ready = 1'b1;
    restart   = 1'b1;
    step();
    out_ready = 1'b0;
    restart   = 1'b0;
    next_idx  = 0;
    checkOutput("restart_cpu_rst", cpu_rst, 1'b1);
    checkOutput("restart_valid", out_valid, 1'b0);
    checkOutput("restart_sel", {ssd_sel, led_sel}, '0);
`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
    checkOutput("restart_ts", out_ts, 32'd0);
`endif
    n = 0;
    while (cpu_rst === 1'b1 && n < 20) begin
      n++;
      step();
    end
    checkOutput("restart_rst_cycles", n, RST_CYCLES);
    leds = 16'h3C3C;
    ssd  = 13'h0F0F;
    runSample(32'hFFFF_FFFF, 1'b0, lat);
    checkOutput("restart_latency", lat, 6);
    checkOutput("restart_idx", out_idx, 4'd0);
    checkOutput("restart_leds", out_leds, 16'h3C3C);
`ifdef CPU_DEBUG_SCANNER_TIMESTAMP_EN
    checkOutput("restart_first_ts", out_ts, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
